// File: rtl/mem_ctrl.sv
// Sequencing initiator for the 32 kB main-memory array: single-word writes and
// critical-word-first wrapping line reads with fixed setup/access/hold phases.
module mem_ctrl #(
    parameter int ADDR_W     = 15,
    parameter int LINE_WORDS = 4,
    parameter int WAIT_CYC   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_strb,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_last,
    output logic              wr_done,
    output logic              mem_ce,
    output logic              mem_oe,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [3:0]        mem_strb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_i,
    input  logic [31:0]       mem_data_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_ACCESS,
        WR_SETUP,
        WR_ACCESS,
        WR_HOLD
    } state_t;

    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(WAIT_CYC - 1);
    localparam logic [3:0]        LAST_BEAT = 4'(LINE_WORDS - 1);
    // Byte-address bits that step within a line; everything else stays fixed.
    localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(LINE_WORDS * 4 - 4);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic              init_q;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [3:0]        beat_q, beat_d;

    logic              mem_ce_q, mem_ce_d;
    logic              mem_oe_q, mem_oe_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [3:0]        mem_strb_q, mem_strb_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;
    logic              wr_done_q, wr_done_d;
    logic [ADDR_W-1:0] next_addr;

    // init_q keeps req_ready low for the first cycle after reset.
    assign req_ready = (state_q == IDLE) && init_q;
    assign next_addr = (mem_addr_q & ~WRAP_MASK) | ((mem_addr_q + ADDR_W'(4)) & WRAP_MASK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            init_q      <= 1'b0;
            wait_q      <= '0;
            beat_q      <= '0;
            mem_ce_q    <= 1'b1;
            mem_oe_q    <= 1'b0;
            mem_wr_q    <= 1'b1;
            mem_rd_q    <= 1'b1;
            mem_strb_q  <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= 1'b1;
            wait_q      <= wait_d;
            beat_q      <= beat_d;
            mem_ce_q    <= mem_ce_d;
            mem_oe_q    <= mem_oe_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_strb_q  <= mem_strb_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Outputs are registered, so each branch programs the values for the
    // state being entered at this edge.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        beat_d      = beat_q;
        mem_ce_d    = mem_ce_q;
        mem_oe_d    = mem_oe_q;
        mem_wr_d    = mem_wr_q;
        mem_rd_d    = mem_rd_q;
        mem_strb_d  = mem_strb_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = 1'b0;
        wr_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    mem_ce_d   = 1'b0;
                    mem_wr_d   = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = req_addr & WORD_MASK;
                    if (req_wr) begin
                        state_d    = WR_SETUP;
                        mem_oe_d   = 1'b1;
                        mem_strb_d = req_strb;
                        mem_data_d = req_wdata;
                    end else begin
                        state_d    = RD_SETUP;
                        mem_oe_d   = 1'b0;
                        mem_strb_d = '0;
                        beat_d     = '0;
                    end
                end
            end
            RD_SETUP: begin
                state_d  = RD_ACCESS;
                mem_rd_d = 1'b0;
                wait_d   = '0;
            end
            RD_ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    mem_rd_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mem_data_o;
                    if (beat_q == LAST_BEAT) begin
                        rsp_last_d = 1'b1;
                        state_d    = IDLE;
                        mem_ce_d   = 1'b1;
                    end else begin
                        state_d    = RD_SETUP;
                        beat_d     = beat_q + 4'd1;
                        mem_addr_d = next_addr;
                    end
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            WR_SETUP: begin
                state_d  = WR_ACCESS;
                mem_wr_d = 1'b0;
                wait_d   = '0;
            end
            WR_ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    state_d   = WR_HOLD;
                    mem_wr_d  = 1'b1;
                    wr_done_d = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            WR_HOLD: begin
                state_d    = IDLE;
                mem_ce_d   = 1'b1;
                mem_oe_d   = 1'b0;
                mem_strb_d = '0;
            end
            default: begin
                state_d  = IDLE;
                mem_ce_d = 1'b1;
                mem_oe_d = 1'b0;
                mem_wr_d = 1'b1;
                mem_rd_d = 1'b1;
            end
        endcase
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_last   = rsp_last_q;
    assign wr_done    = wr_done_q;
    assign mem_ce     = mem_ce_q;
    assign mem_oe     = mem_oe_q;
    assign mem_wr     = mem_wr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_strb   = mem_strb_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data_i = mem_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural SRAM, word-array reference model,
// directed and randomized read/write traffic with cycle-exact timing checks.
module tb_mem_ctrl;
    localparam int ADDR_W = 15;
    localparam int LW     = 4;
    localparam int W      = 3;
    localparam int NWORDS = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_wr = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [3:0]  req_strb = '0;
    logic [31:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_last, wr_done;
    logic [31:0] rsp_data;
    logic mem_ce, mem_oe, mem_wr, mem_rd;
    logic [3:0] mem_strb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_data_i, mem_data_o;

    logic [31:0] arr     [0:NWORDS-1];
    logic [31:0] ref_mem [0:NWORDS-1];
    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .WAIT_CYC(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_strb(req_strb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .wr_done(wr_done),
        .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_strb(mem_strb), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural array: outputs drive only while selected for reading; bytes
    // are written on every clock edge during the write pulse.
    assign mem_data_o = (!mem_ce && !mem_rd && !mem_oe) ? arr[mem_addr[ADDR_W-1:2]] : 32'hDEAD_BEEF;
    logic [31:0] sram_w;
    always @(posedge clk) begin
        if (!mem_ce && !mem_wr && mem_oe) begin
            sram_w = arr[mem_addr[ADDR_W-1:2]];
            for (int b = 0; b < 4; b++)
                if (mem_strb[b]) sram_w[8*b +: 8] = mem_data_i[8*b +: 8];
            arr[mem_addr[ADDR_W-1:2]] <= sram_w;
        end
    end

    // Array-side invariants, checked every cycle once out of reset.
    logic prev_oe;
    logic [ADDR_W-1:0] prev_addr;
    logic [3:0] prev_strb;
    always @(negedge clk) begin
        if (mon_en) begin
            check("inv_wr_rd_both_low", {31'd0, (!mem_wr && !mem_rd)}, 32'd0);
            if (!mem_wr || !mem_rd) begin
                check("inv_oe_stable", {31'd0, mem_oe}, {31'd0, prev_oe});
                check("inv_addr_stable", {17'd0, mem_addr}, {17'd0, prev_addr});
                check("inv_strb_stable", {28'd0, mem_strb}, {28'd0, prev_strb});
            end
        end
        prev_oe   <= mem_oe;
        prev_addr <= mem_addr;
        prev_strb <= mem_strb;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request and return just after the accepting edge.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        bit ok;
        ok = 0;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_strb = s; req_wdata = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        check("accept_within_bound", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = ADDR_W'($urandom);
        req_strb  = 4'($urandom);
        req_wdata = $urandom;
        req_wr    = 1'($urandom);
    endtask

    // Called just after the write's accepting edge; checks the whole write.
    task automatic write_check(input logic [ADDR_W-1:0] a, input logic [3:0] s, input logic [31:0] d);
        int widx;
        widx = int'(a) / 4;
        for (int n = 1; n <= W + 3; n++) begin
            @(negedge clk);
            check("wr_done", {31'd0, wr_done}, {31'd0, (n == W + 2)});
            check("wr_pulse", {31'd0, mem_wr}, {31'd0, !(n >= 2 && n <= W + 1)});
            check("wr_req_ready", {31'd0, req_ready}, {31'd0, (n == W + 3)});
            if (n <= W + 2) begin
                check("wr_ce", {31'd0, mem_ce}, 32'd0);
                check("wr_oe", {31'd0, mem_oe}, 32'd1);
                check("wr_addr", {17'd0, mem_addr}, widx * 4);
                check("wr_strb", {28'd0, mem_strb}, {28'd0, s});
                check("wr_data", mem_data_i, d);
            end else begin
                check("wr_idle_ce", {31'd0, mem_ce}, 32'd1);
                check("wr_idle_oe", {31'd0, mem_oe}, 32'd0);
            end
        end
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[widx][8*b +: 8] = d[8*b +: 8];
        $display("[TB] write addr=%h strb=%b data=%h -> word %h", a, s, d, ref_mem[widx]);
    endtask

    // Called just after the read's accepting edge; optionally holds a write
    // request valid throughout so it is taken back-to-back.
    task automatic read_check(input logic [ADDR_W-1:0] a, input bit b2b,
                              input logic [ADDR_W-1:0] wa, input logic [3:0] ws, input logic [31:0] wd);
        int base, lbase, k, rk, ncyc;
        bit is_rsp;
        base  = int'(a) / 4;
        lbase = base - (base % LW);
        ncyc  = LW * (1 + W) + 1;
        if (b2b) begin
            req_valid = 1'b1; req_wr = 1'b1; req_addr = wa; req_strb = ws; req_wdata = wd;
        end
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            k = (n - 1) / (1 + W);
            if (n < ncyc) begin
                check("rd_ce", {31'd0, mem_ce}, 32'd0);
                check("rd_oe", {31'd0, mem_oe}, 32'd0);
                if ((n - 1) % (1 + W) == 0) begin
                    check("rd_setup_rd", {31'd0, mem_rd}, 32'd1);
                    check("rd_addr", {17'd0, mem_addr}, (lbase + ((base + k) % LW)) * 4);
                end else begin
                    check("rd_access_rd", {31'd0, mem_rd}, 32'd0);
                end
            end else begin
                check("rd_end_ce", {31'd0, mem_ce}, 32'd1);
            end
            is_rsp = (n > 1) && ((n - 1) % (1 + W) == 0);
            rk = k - 1;
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, is_rsp});
            if (is_rsp) begin
                check("rsp_data", rsp_data, ref_mem[lbase + ((base + rk) % LW)]);
                check("rsp_last", {31'd0, rsp_last}, {31'd0, (rk == LW - 1)});
            end
            check("rd_req_ready", {31'd0, req_ready}, {31'd0, (n == ncyc)});
        end
        $display("[TB] read  addr=%h line=%h%s", a, lbase * 4, b2b ? " (write queued)" : "");
        if (b2b) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            write_check(wa, ws, wd);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] ra, wa;
        logic [3:0] ws;
        logic [31:0] wd;
        int sel;
        for (int i = 0; i < NWORDS; i++) begin
            arr[i]     = 32'hA000_0000 + i;
            ref_mem[i] = 32'hA000_0000 + i;
        end

        // Reset held for two edges, released, then ready one cycle later.
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ce", {31'd0, mem_ce}, 32'd1);
        check("rst_wr", {31'd0, mem_wr}, 32'd1);
        check("rst_rd", {31'd0, mem_rd}, 32'd1);
        check("rst_oe", {31'd0, mem_oe}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rst_release_ready", {31'd0, req_ready}, 32'd1);
        $display("[TB] reset released");
        mon_en = 1'b1;

        issue(1'b0, 15'h0100, 4'h0, 32'h0);
        read_check(15'h0100, 1'b0, '0, '0, '0);
        issue(1'b0, 15'h010C, 4'h0, 32'h0);
        read_check(15'h010C, 1'b0, '0, '0, '0);

        issue(1'b1, 15'h7FFC, 4'b0101, 32'h1122_3344);
        write_check(15'h7FFC, 4'b0101, 32'h1122_3344);
        check("strb_merge", ref_mem[13'h1FFF], 32'hA022_1F44);
        issue(1'b0, 15'h7FFC, 4'h0, 32'h0);
        read_check(15'h7FFC, 1'b0, '0, '0, '0);

        issue(1'b1, 15'h0204, 4'b0000, 32'hFFFF_FFFF);
        write_check(15'h0204, 4'b0000, 32'hFFFF_FFFF);

        issue(1'b0, 15'h0208, 4'h0, 32'h0);
        read_check(15'h0208, 1'b1, 15'h0204, 4'b1111, 32'hCAFE_F00D);
        issue(1'b0, 15'h0200, 4'h0, 32'h0);
        read_check(15'h0200, 1'b0, '0, '0, '0);

        // Reset asserted in cycle 7 of a read.
        issue(1'b0, 15'h0300, 4'h0, 32'h0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ce", {31'd0, mem_ce}, 32'd1);
        check("midrst_rd", {31'd0, mem_rd}, 32'd1);
        check("midrst_wr", {31'd0, mem_wr}, 32'd1);
        check("midrst_oe", {31'd0, mem_oe}, 32'd0);
        check("midrst_strb", {28'd0, mem_strb}, 32'd0);
        check("midrst_addr", {17'd0, mem_addr}, 32'd0);
        check("midrst_wdata", mem_data_i, 32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_rsp_last", {31'd0, rsp_last}, 32'd0);
        check("midrst_rsp_data", rsp_data, 32'd0);
        check("midrst_wr_done", {31'd0, wr_done}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            check("midrst_ready_back", {31'd0, req_ready}, 32'd1);
        end
        $display("[TB] reset mid-read done");
        issue(1'b0, 15'h0304, 4'h0, 32'h0);
        read_check(15'h0304, 1'b0, '0, '0, '0);

        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 2));
            ra  = ADDR_W'($urandom);
            wa  = ADDR_W'($urandom);
            ws  = 4'($urandom);
            wd  = $urandom;
            if (t % 5 == 1) wa = ra;
            if (sel == 0) begin
                issue(1'b1, wa, ws, wd);
                write_check(wa, ws, wd);
            end else begin
                issue(1'b0, ra, 4'h0, 32'h0);
                read_check(ra, (sel == 2), wa, ws, wd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
